// File: rtl/param_fir_mac_if.sv
// Sample/coefficient/result bundle for param_fir_mac.
// The master side is the sample source plus coefficient writer and the
// result consumer; the slave side is the filter itself.
interface param_fir_mac_if #(
    parameter int DATA_W = 18,
    parameter int COEF_W = 18,
    parameter int ACC_W  = 38,
    parameter int ADDR_W = 3
);
    logic signed [DATA_W-1:0] data_in;
    logic                     in_valid;
    logic                     in_ready;
    logic                     coef_we;
    logic        [ADDR_W-1:0] coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic                     coef_wr_err;
    logic signed [ACC_W-1:0]  fir_result;
    logic                     out_valid;

    modport master (
        output data_in, in_valid, coef_we, coef_addr, coef_data,
        input  in_ready, coef_wr_err, fir_result, out_valid
    );

    modport slave (
        input  data_in, in_valid, coef_we, coef_addr, coef_data,
        output in_ready, coef_wr_err, fir_result, out_valid
    );
endinterface

// File: rtl/param_fir_mac.sv
// Time-multiplexed FIR filter built around one signed multiply-accumulate.
// Each accepted sample is pushed into a circular delay line, then M taps are
// accumulated one per enabled cycle and the sum is published with a one-cycle
// out_valid strobe. SYMM=1 folds mirrored taps through a pre-adder so only
// TAPS/2 coefficients are stored and only TAPS/2 MAC cycles are needed.
// The accumulator wraps modulo 2^ACC_W; size ACC_W for the worst-case sum.
module param_fir_mac #(
    parameter int DATA_W = 18,
    parameter int COEF_W = 18,
    parameter int TAPS   = 8,
    parameter int SYMM   = 0,
    parameter int ACC_W  = 38
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clk_ena,
    param_fir_mac_if.slave bus
);

    localparam int M      = (SYMM != 0) ? TAPS / 2 : TAPS;
    localparam int ADDR_W = $clog2(TAPS);
    localparam int K_W    = (M > 1) ? $clog2(M) : 1;
    localparam int TERM_W = DATA_W + ((SYMM != 0) ? 1 : 0);
    localparam int PROD_W = COEF_W + TERM_W;

    localparam logic [ADDR_W:0] NCOEF = (ADDR_W + 1)'(M);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic        [ADDR_W-1:0] wr_ptr;
    logic        [K_W-1:0]    k_cnt;
    logic signed [DATA_W-1:0] x_mem    [TAPS];
    logic signed [COEF_W-1:0] coef_mem [M];
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  fir_result_q;
    logic                     out_valid_q;
    logic                     coef_wr_err_q;

    logic                     in_ready_c;
    logic                     accept;
    logic                     last_k;
    logic                     addr_in_range;
    logic                     coef_wr_ok;
    logic                     coef_wr_bad;
    logic signed [COEF_W-1:0] coef_k;
    logic signed [DATA_W-1:0] x_a;
    logic signed [TERM_W-1:0] term;
    logic signed [PROD_W-1:0] prod;

    // Location of x[n-j]: the newest sample sits just behind wr_ptr, so the
    // slot is (wr_ptr - 1 - j) mod TAPS, computed without a general modulo.
    function automatic logic [ADDR_W-1:0] tap_index(
        input logic [ADDR_W-1:0] ptr,
        input logic [ADDR_W-1:0] j
    );
        logic [ADDR_W+1:0] s;
        s = {2'b00, ptr} + (ADDR_W + 2)'(TAPS - 1) - {2'b00, j};
        if (s >= (ADDR_W + 2)'(TAPS)) begin
            s = s - (ADDR_W + 2)'(TAPS);
        end
        return ADDR_W'(s);
    endfunction

    // Full-width product sign-extended onto the accumulator width.
    function automatic logic signed [ACC_W-1:0] sext_prod(
        input logic signed [PROD_W-1:0] p
    );
        return {{(ACC_W - PROD_W){p[PROD_W-1]}}, p};
    endfunction

    // Accumulation is plain two's complement wrap; no saturation is applied.
    function automatic logic signed [ACC_W-1:0] acc_wrap_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
        return a + b;
    endfunction

    assign last_k        = (k_cnt == K_W'(M - 1));
    assign addr_in_range = ({1'b0, bus.coef_addr} < NCOEF);
    assign accept        = bus.in_valid & in_ready_c;
    assign coef_wr_ok    = clk_ena & bus.coef_we & (state_q == IDLE) & addr_in_range;
    assign coef_wr_bad   = clk_ena & bus.coef_we & ~((state_q == IDLE) & addr_in_range);

    assign coef_k = coef_mem[k_cnt];
    assign x_a    = x_mem[tap_index(wr_ptr, ADDR_W'(k_cnt))];

    generate
        if (SYMM != 0) begin : g_fold
            logic signed [DATA_W-1:0] x_b;
            assign x_b = x_mem[tap_index(wr_ptr, ADDR_W'(TAPS - 1) - ADDR_W'(k_cnt))];
            // Pre-add the mirrored taps one bit wider so the fold cannot overflow.
            always_comb begin
                term = {x_a[DATA_W-1], x_a} + {x_b[DATA_W-1], x_b};
            end
        end else begin : g_direct
            // Direct form: the term is just the delayed sample.
            always_comb begin
                term = x_a;
            end
        end
    endgenerate

    assign prod = PROD_W'(coef_k) * PROD_W'(term);

    // State register; a disabled cycle freezes the sequence in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else if (clk_ena) begin
            state_q <= state_d;
        end
    end

    // Next state and the combinational ready: IDLE accepts, MAC runs M taps,
    // DONE publishes the sum for one cycle.
    always_comb begin
        state_d    = state_q;
        in_ready_c = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_c = clk_ena;
                if (bus.in_valid && clk_ena) begin
                    state_d = MAC;
                end
            end
            MAC: begin
                if (last_k) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Delay line, write pointer, tap counter and accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            k_cnt  <= '0;
            acc    <= '0;
            for (int i = 0; i < TAPS; i++) begin
                x_mem[i] <= '0;
            end
        end else if (clk_ena) begin
            if (accept) begin
                x_mem[wr_ptr] <= bus.data_in;
                wr_ptr        <= (wr_ptr == ADDR_W'(TAPS - 1)) ? '0 : wr_ptr + 1'b1;
                acc           <= '0;
                k_cnt         <= '0;
            end else if (state_q == MAC) begin
                acc   <= acc_wrap_add(acc, sext_prod(prod));
                k_cnt <= last_k ? '0 : k_cnt + 1'b1;
            end
        end
    end

    // Coefficient bank; writes land only while idle so a running sum never
    // mixes old and new coefficients.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < M; i++) begin
                coef_mem[i] <= '0;
            end
        end else if (coef_wr_ok) begin
            coef_mem[K_W'(bus.coef_addr)] <= bus.coef_data;
        end
    end

    // Result register plus the one-cycle out_valid and write-error strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fir_result_q  <= '0;
            out_valid_q   <= 1'b0;
            coef_wr_err_q <= 1'b0;
        end else if (clk_ena) begin
            out_valid_q   <= (state_q == DONE);
            coef_wr_err_q <= coef_wr_bad;
            if (state_q == DONE) begin
                fir_result_q <= acc;
            end
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.fir_result  = fir_result_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.coef_wr_err = coef_wr_err_q;

endmodule

// File: doc/param_fir_mac.md
# param_fir_mac

Parametrised, time-multiplexed FIR filter with a single signed multiply-accumulate unit, a runtime-writable coefficient bank, and an optional symmetric (pre-add folded) mode. It replaces fixed 8-tap, fixed-coefficient filters in the filter datapath. It sits between the sample source and the downstream result consumer, using an in_valid/in_ready input handshake and a one-cycle out_valid result strobe. It trades throughput (one sample per M+2 cycles) for a single multiplier.

## Interface
- DATA_W, 18: signed sample width.
- COEF_W, 18: signed coefficient width.
- TAPS, 8: filter length, ≥2; must be even when SYMM=1.
- SYMM, 0: 1 = symmetric mode, TAPS/2 stored coefficients, pre-adder folding.
- ACC_W, 38: accumulator/result width; integrator chooses ≥ DATA_W+COEF_W+SYMM+clog2(TAPS) for overflow-free use.
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- clk_ena  in  1  global enable; when low, all state is frozen.
- data_in  in  DATA_W  signed input sample.
- in_valid  in  1  data_in is valid.
- in_ready  out  1  combinational: (state==IDLE) & clk_ena.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  clog2(TAPS)  coefficient index k.
- coef_data  in  COEF_W  signed coefficient value.
- coef_wr_err  out  1  one-cycle pulse: write rejected.
- fir_result  out  ACC_W  signed filter output, registered.
- out_valid  out  1  one-cycle strobe; fir_result is new.

## Operation
- Define M = SYMM ? TAPS/2 : TAPS, and NCOEF = M.
- Delay line: a circular buffer of TAPS samples with write pointer wr_ptr. x[n-j] is the sample accepted j samples ago.
- Coefficient bank: NCOEF registers, all reset to 0.
- coef_we is effective only on an enabled edge in IDLE with coef_addr < NCOEF.
  - coef_we in MAC or DONE: no write; coef_wr_err pulses.
  - coef_addr ≥ NCOEF: no write; coef_wr_err pulses.
- FSM states: IDLE, MAC, DONE.
  - IDLE: on an accept (in_valid & in_ready), write data_in at wr_ptr, advance wr_ptr (wraps TAPS-1→0), clear acc, set k=0, go to MAC.
  - MAC: on each enabled edge, acc += coef[k]·term, then k++.
    - SYMM=0: term = x[n-k].
    - SYMM=1: term = sext(x[n-k]) + sext(x[n-(TAPS-1-k)]), DATA_W+1 bits.
    - After the edge with k=M-1, go to DONE.
  - DONE: fir_result <= acc, out_valid <= 1, go to IDLE.
- out_valid clears on the next enabled edge.
- Arithmetic: signed two's complement. Products are full width, sign-extended to ACC_W. acc wraps modulo 2^ACC_W; there is no saturation.
- Simultaneous coefficient write and sample accept in IDLE: both occur, and the new sample's computation uses the new coefficient.
- clk_ena low: FSM, counters, acc, delay line, coefficients, out_valid and coef_wr_err all hold. in_ready is 0. Writes and accepts are ignored (no error pulse).
- Reset (asserted at any time, including mid-MAC) forces:
  - state = IDLE, wr_ptr = 0, k = 0.
  - delay line, acc and coefficients = 0.
  - fir_result = 0, out_valid = 0, coef_wr_err = 0.
  - Any in-flight result is discarded.

## Timing
- Let the accept occur on enabled edge E0.
  - MAC products accumulate on edges E1..EM.
  - fir_result and out_valid update on edge E(M+1).
- in_ready returns high after E(M+1). The earliest next accept is E(M+2), so throughput is 1 sample per M+2 enabled cycles.
- Disabled cycles stretch latency one-for-one. Results are unaffected.
- coef_wr_err asserts the cycle after the offending edge and lasts one enabled cycle.

## Test plan
- Impulse response, TAPS=8, SYMM=0:
  - Stimulus: load coef = 1..8, then send samples 1,0,0,…
  - Required: fir_result = 1,2,3,4,5,6,7,8, then 0.
  - Check out_valid at E9 after each accept, in_ready low for 9 cycles.
- Symmetric mode, TAPS=8, SYMM=1:
  - Stimulus: load coef = 1,2,3,4, then send an impulse.
  - Required: outputs 1,2,3,4,4,3,2,1,0; each result at E5.
- Wrap case, ACC_W=38:
  - Stimulus: all coef = −131072, all samples −131072.
  - Required: the steady-state sum is 2^37, which wraps to fir_result = −2^37.
- Coefficient rejection:
  - Stimulus A: coef_we mid-MAC. Required: coef_wr_err pulse, result computed with the old coefficients.
  - Stimulus B: coef_addr ≥ NCOEF in IDLE. Required: coef_wr_err pulse.
  - Stimulus C: coef_we together with an accept in IDLE. Required: the new coefficient is used.
- Enable gating:
  - Stimulus: drop clk_ena for 5 cycles at MAC k=3.
  - Required: result identical, latency +5, in_ready 0 while disabled.
- Reset:
  - Stimulus: assert reset asynchronously mid-MAC.
  - Required: immediately fir_result = 0, out_valid = 0, in_ready = 1 after release. A following impulse returns all-zero outputs until coefficients are reloaded.
